// File: rtl/execute_stage.sv
// Y86-64 execute stage: operand select, ALU, condition codes, branch/cmov condition,
// and the E->M pipeline register feeding the memory stage.
module execute_stage #(
    parameter int unsigned XLEN   = 64,
    parameter logic [2:0]  CC_RST = 3'b100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            M_bubble,
    input  logic [0:3]      E_stat,
    input  logic [3:0]      E_icode,
    input  logic [3:0]      E_ifun,
    input  logic [XLEN-1:0] E_valC,
    input  logic [XLEN-1:0] E_valA,
    input  logic [XLEN-1:0] E_valB,
    input  logic [3:0]      E_dstE,
    input  logic [3:0]      E_dstM,
    input  logic [0:3]      m_stat,
    input  logic [0:3]      W_stat,
    output logic [XLEN-1:0] e_valE,
    output logic [3:0]      e_dstE,
    output logic            e_Cnd,
    output logic [2:0]      cc,
    output logic [0:3]      M_stat,
    output logic [3:0]      M_icode,
    output logic            M_Cnd,
    output logic [XLEN-1:0] M_valE,
    output logic [XLEN-1:0] M_valA,
    output logic [3:0]      M_dstE,
    output logic [3:0]      M_dstM
);
    localparam int unsigned MSB = XLEN - 1;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [0:3] STAT_AOK = 4'b1000;
    localparam logic [3:0] REG_NONE = 4'hF;

    logic [XLEN-1:0] alu_a, alu_b, sum, diff, alu_res;
    logic            alu_of, set_cc, cond, zf, sf, of;
    logic [2:0]      cc_d, cc_q;

    logic [0:3]      m_stat_d, m_stat_q;
    logic [3:0]      m_icode_d, m_icode_q;
    logic            m_cnd_d, m_cnd_q;
    logic [XLEN-1:0] m_vale_d, m_vale_q;
    logic [XLEN-1:0] m_vala_d, m_vala_q;
    logic [3:0]      m_dste_d, m_dste_q;
    logic [3:0]      m_dstm_d, m_dstm_q;

    // Operand selection by instruction class.
    always_comb begin : alu_operands
        alu_a = '0;
        alu_b = '0;
        case (E_icode)
            I_RRMOVQ, I_OPQ:              alu_a = E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
            I_CALL, I_PUSHQ:              alu_a = XLEN'(0) - XLEN'(8);
            I_RET, I_POPQ:                alu_a = XLEN'(8);
            default:                      alu_a = '0;
        endcase
        case (E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = E_valB;
            default:                                                  alu_b = '0;
        endcase
    end

    // Everything but OPq is an address/move add; OPq with an undefined ifun yields zero.
    always_comb begin : alu
        sum     = alu_b + alu_a;
        diff    = alu_b - alu_a;
        alu_res = sum;
        alu_of  = (alu_a[MSB] == alu_b[MSB]) && (sum[MSB] != alu_a[MSB]);
        if (E_icode == I_OPQ) begin
            case (E_ifun)
                4'h0: ;
                4'h1: begin
                    alu_res = diff;
                    alu_of  = (alu_b[MSB] != alu_a[MSB]) && (diff[MSB] != alu_b[MSB]);
                end
                4'h2: begin
                    alu_res = alu_b & alu_a;
                    alu_of  = 1'b0;
                end
                4'h3: begin
                    alu_res = alu_b ^ alu_a;
                    alu_of  = 1'b0;
                end
                default: begin
                    alu_res = '0;
                    alu_of  = 1'b0;
                end
            endcase
        end
    end

    // Flags update only for a valid OPq while no older stage has faulted.
    always_comb begin : cc_next
        set_cc = (E_icode == I_OPQ) && (E_ifun <= 4'd3) && (E_stat == STAT_AOK)
                 && (m_stat == STAT_AOK) && (W_stat == STAT_AOK);
        cc_d   = cc_q;
        if (set_cc) begin
            cc_d = {(alu_res == '0), alu_res[MSB], alu_of};
        end
    end

    always_comb begin : condition
        {zf, sf, of} = cc_q;
        case (E_ifun)
            4'h0:    cond = 1'b1;
            4'h1:    cond = (sf ^ of) | zf;
            4'h2:    cond = sf ^ of;
            4'h3:    cond = zf;
            4'h4:    cond = ~zf;
            4'h5:    cond = ~(sf ^ of);
            4'h6:    cond = ~(sf ^ of) & ~zf;
            default: cond = 1'b0;
        endcase
        e_Cnd  = ((E_icode == I_RRMOVQ) || (E_icode == I_JXX)) ? cond : 1'b0;
        e_dstE = ((E_icode == I_RRMOVQ) && !cond) ? REG_NONE : E_dstE;
        e_valE = alu_res;
    end

    always_comb begin : m_next
        m_stat_d  = E_stat;
        m_icode_d = E_icode;
        m_cnd_d   = e_Cnd;
        m_vale_d  = e_valE;
        m_vala_d  = E_valA;
        m_dste_d  = e_dstE;
        m_dstm_d  = E_dstM;
        if (M_bubble) begin
            m_stat_d  = STAT_AOK;
            m_icode_d = I_NOP;
            m_cnd_d   = 1'b0;
            m_vale_d  = '0;
            m_vala_d  = '0;
            m_dste_d  = REG_NONE;
            m_dstm_d  = REG_NONE;
        end
    end

    always_ff @(posedge clk) begin : regs
        if (!rst_n) begin
            cc_q      <= CC_RST;
            m_stat_q  <= STAT_AOK;
            m_icode_q <= I_NOP;
            m_cnd_q   <= 1'b0;
            m_vale_q  <= '0;
            m_vala_q  <= '0;
            m_dste_q  <= REG_NONE;
            m_dstm_q  <= REG_NONE;
        end else begin
            cc_q      <= cc_d;
            m_stat_q  <= m_stat_d;
            m_icode_q <= m_icode_d;
            m_cnd_q   <= m_cnd_d;
            m_vale_q  <= m_vale_d;
            m_vala_q  <= m_vala_d;
            m_dste_q  <= m_dste_d;
            m_dstm_q  <= m_dstm_d;
        end
    end

    assign cc      = cc_q;
    assign M_stat  = m_stat_q;
    assign M_icode = m_icode_q;
    assign M_Cnd   = m_cnd_q;
    assign M_valE  = m_vale_q;
    assign M_valA  = m_vala_q;
    assign M_dstE  = m_dste_q;
    assign M_dstM  = m_dstm_q;

endmodule
